// File: rtl/da_pkg.sv
// Shared types and defaults for the display-adaptor ping-pong line-buffer scheduler.
package da_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'b00,
    BUF_FILLING  = 2'b01,
    BUF_FULL     = 2'b10,
    BUF_DRAINING = 2'b11
  } buf_state_e;

  localparam int DA_PX_PER_LINE = 640;
  localparam int DA_ADDR_W      = 10;

  function automatic logic is_writable(buf_state_e s);
    return (s == BUF_EMPTY) || (s == BUF_FILLING);
  endfunction

endpackage

// File: rtl/da_buf_tracker.sv
// Lifecycle state and pixel counter for a single line buffer.
module da_buf_tracker
  import da_pkg::*;
#(
  parameter int PX_PER_LINE = DA_PX_PER_LINE,
  parameter int ADDR_W      = DA_ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PX_PER_LINE - 1);

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign last_o  = (cnt_q == LAST_IDX);
  assign state_o = state_q;
  // A buffer is never filled and drained at once, so one counter addresses both sides.
  assign addr_o  = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = BUF_EMPTY;
      cnt_d   = '0;
    end else if (rd_en_i) begin
      if (last_o) begin
        state_d = BUF_EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (wr_en_i) begin
      if (last_o) begin
        state_d = BUF_FULL;
        cnt_d   = '0;
      end else begin
        state_d = BUF_FILLING;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      state_d = BUF_DRAINING;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= BUF_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/da_buffer_scheduler.sv
// Ping-pong line-buffer scheduler between pixel filler and scan-out.
// Optional DA_UNDERRUN_COUNT_EN adds a saturating 16-bit underrun_count output.
module da_buffer_scheduler
  import da_pkg::*;
#(
  parameter int PX_PER_LINE = DA_PX_PER_LINE,
  parameter int ADDR_W      = DA_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs_display,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic              line_start,
  input  logic              active,
  output logic              we0,
  output logic              we1,
  output logic              re0,
  output logic              re1,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic              sel_buf1,
  output logic              sel_blank,
  output logic              buf0_empty,
  output logic              buf1_empty,
  output logic              underrun
`ifdef DA_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]       underrun_count
`endif
);

  logic [1:0] st0_raw, st1_raw;
  buf_state_e st0, st1, wr_st, rd_st, ev_st;
  logic       last0, last1, wr_last, rd_last;
  logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic       sel_buf1_q, sel_buf1_d, sel_blank_q, sel_blank_d;
  logic       underrun_q, underrun_d;
  logic       en, accept, read, rd_done, ls, abort, eval_sel, start;

  assign st0     = buf_state_e'(st0_raw);
  assign st1     = buf_state_e'(st1_raw);
  assign en      = cs_display && !reset;
  assign wr_st   = wr_sel_q ? st1 : st0;
  assign rd_st   = rd_sel_q ? st1 : st0;
  assign wr_last = wr_sel_q ? last1 : last0;
  assign rd_last = rd_sel_q ? last1 : last0;

  assign fill_ready = en && is_writable(wr_st);
  assign accept     = fill_valid && fill_ready;
  assign read       = en && active && (rd_st == BUF_DRAINING);
  assign rd_done    = read && rd_last;

  // A short line retires the draining buffer and immediately offers the other one.
  assign ls       = en && line_start;
  assign abort    = ls && (rd_st == BUF_DRAINING);
  assign eval_sel = rd_sel_q ^ abort;
  assign ev_st    = eval_sel ? st1 : st0;
  assign start    = ls && (ev_st == BUF_FULL);

  assign we0 = accept && !wr_sel_q;
  assign we1 = accept && wr_sel_q;
  assign re0 = read && !rd_sel_q;
  assign re1 = read && rd_sel_q;

  da_buf_tracker #(.PX_PER_LINE(PX_PER_LINE), .ADDR_W(ADDR_W)) u_buf0 (
    .clock_i (clock),
    .reset_i (reset),
    .wr_en_i (we0),
    .rd_en_i (re0),
    .start_i (start && !eval_sel),
    .abort_i (abort && !rd_sel_q),
    .state_o (st0_raw),
    .addr_o  (addr0),
    .last_o  (last0)
  );

  da_buf_tracker #(.PX_PER_LINE(PX_PER_LINE), .ADDR_W(ADDR_W)) u_buf1 (
    .clock_i (clock),
    .reset_i (reset),
    .wr_en_i (we1),
    .rd_en_i (re1),
    .start_i (start && eval_sel),
    .abort_i (abort && rd_sel_q),
    .state_o (st1_raw),
    .addr_o  (addr1),
    .last_o  (last1)
  );

  always_comb begin
    wr_sel_d    = wr_sel_q ^ (accept && wr_last);
    rd_sel_d    = rd_sel_q ^ (abort || rd_done);
    sel_buf1_d  = sel_buf1_q;
    sel_blank_d = sel_blank_q;
    underrun_d  = 1'b0;
    if (rd_done) begin
      sel_blank_d = 1'b1;
    end
    if (ls) begin
      if (start) begin
        sel_buf1_d  = eval_sel;
        sel_blank_d = 1'b0;
      end else begin
        underrun_d  = 1'b1;
        sel_blank_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      sel_buf1_q  <= 1'b0;
      sel_blank_q <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      sel_buf1_q  <= sel_buf1_d;
      sel_blank_q <= sel_blank_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sel_buf1   = sel_buf1_q;
  assign sel_blank  = sel_blank_q || !cs_display;
  assign buf0_empty = (st0 == BUF_EMPTY);
  assign buf1_empty = (st1 == BUF_EMPTY);
  assign underrun   = underrun_q;

`ifdef DA_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ucnt_q <= '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_da_buffer_scheduler.sv
// Self-checking bench for da_buffer_scheduler with a 4-pixel line and a behavioural buffer model.
module tb_da_buffer_scheduler;

  localparam int PX = 4;
  localparam int AW = 3;
  localparam int S_EMPTY = 0, S_FILLING = 1, S_FULL = 2, S_DRAINING = 3;

  logic          clock = 1'b0;
  logic          reset, cs_display, fill_valid, line_start, active;
  logic          fill_ready, we0, we1, re0, re1;
  logic [AW-1:0] addr0, addr1;
  logic          sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun;
`ifdef DA_UNDERRUN_COUNT_EN
  logic [15:0]   underrun_count;
`endif

  int nCmp = 0;
  int nFail = 0;

  int mState[2];
  int mCnt[2];
  int mWr, mRd, mUcount;
  bit mSelBuf1, mSelBlank, mUnderrun;
  bit eReady;
  bit eWe[2];
  bit eRe[2];

  always #5 clock = ~clock;

  da_buffer_scheduler #(.PX_PER_LINE(PX), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cs_display (cs_display),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .line_start (line_start),
    .active     (active),
    .we0        (we0),
    .we1        (we1),
    .re0        (re0),
    .re1        (re1),
    .addr0      (addr0),
    .addr1      (addr1),
    .sel_buf1   (sel_buf1),
    .sel_blank  (sel_blank),
    .buf0_empty (buf0_empty),
    .buf1_empty (buf1_empty),
    .underrun   (underrun)
`ifdef DA_UNDERRUN_COUNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  task automatic model_reset();
    mState[0] = S_EMPTY; mState[1] = S_EMPTY;
    mCnt[0] = 0; mCnt[1] = 0;
    mWr = 0; mRd = 0; mUcount = 0;
    mSelBuf1 = 0; mSelBlank = 1; mUnderrun = 0;
  endtask

  // Expected same-cycle outputs from the model state and the current inputs.
  task automatic model_comb();
    bit en;
    en = cs_display && !reset;
    eReady = en && (mState[mWr] == S_EMPTY || mState[mWr] == S_FILLING);
    eWe[0] = eReady && fill_valid && (mWr == 0);
    eWe[1] = eReady && fill_valid && (mWr == 1);
    eRe[0] = en && active && (mState[mRd] == S_DRAINING) && (mRd == 0);
    eRe[1] = en && active && (mState[mRd] == S_DRAINING) && (mRd == 1);
  endtask

  task automatic model_tick();
    int snap[2];
    int rb, b;
    if (reset) begin
      model_reset();
      return;
    end
    snap = mState;
    rb = mRd;
    mUnderrun = 0;
    model_comb();
    if (eWe[mWr]) begin
      mState[mWr] = S_FILLING;
      mCnt[mWr]++;
      if (mCnt[mWr] == PX) begin
        mState[mWr] = S_FULL; mCnt[mWr] = 0; mWr = 1 - mWr;
      end
    end
    if (eRe[rb]) begin
      mCnt[rb]++;
      if (mCnt[rb] == PX) begin
        mState[rb] = S_EMPTY; mCnt[rb] = 0; mRd = 1 - rb; mSelBlank = 1;
      end
    end
    if (cs_display && line_start) begin
      if (snap[rb] == S_DRAINING) begin
        mState[rb] = S_EMPTY; mCnt[rb] = 0; mRd = 1 - rb;
      end
      b = mRd;
      if (snap[b] == S_FULL) begin
        mState[b] = S_DRAINING; mSelBuf1 = (b == 1); mSelBlank = 0;
      end else begin
        mUnderrun = 1; mSelBlank = 1;
        if (mUcount < 65535) mUcount++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic cs, input logic fv, input logic ls, input logic act);
    reset = r; cs_display = cs; fill_valid = fv; line_start = ls; active = act;
  endtask

  task automatic settle();
    model_comb();
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 0); settle();
    nCmp++; if (fill_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_fill_ready got %b want 0", fill_ready); end
    nCmp++; if ({we0, we1, re0, re1} !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_enables got %b want 0000", {we0, we1, re0, re1}); end
    tick();
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun} !== 5'b01110) begin nFail++; $display("[TB] FAIL reset_regs got %b want 01110", {sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun}); end
    nCmp++; if ({addr0, addr1} !== '0) begin nFail++; $display("[TB] FAIL reset_addr got %0d/%0d want 0/0", addr0, addr1); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < PX; i++) begin
      drive(0, 1, 1, 0, 0); settle();
      nCmp++; if ({fill_ready, we0, we1} !== 3'b110) begin nFail++; $display("[TB] FAIL fill_we0 px %0d got %b want 110", i, {fill_ready, we0, we1}); end
      nCmp++; if (addr0 !== AW'(i)) begin nFail++; $display("[TB] FAIL fill_addr0 got %0d want %0d", addr0, i); end
      tick();
    end
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({buf0_empty, buf1_empty, fill_ready} !== 3'b011) begin nFail++; $display("[TB] FAIL fill_full got %b want 011", {buf0_empty, buf1_empty, fill_ready}); end
    tick();
    drive(0, 1, 1, 0, 0); settle();
    nCmp++; if ({we0, we1, addr1} !== {2'b01, AW'(0)}) begin nFail++; $display("[TB] FAIL fill_switch got we %b%b addr1 %0d want we 01 addr1 0", we0, we1, addr1); end
    tick();
  endtask

  task automatic test_drain();
    drive(0, 1, 0, 1, 0); settle();
    nCmp++; if ({re0, re1} !== 2'b00) begin nFail++; $display("[TB] FAIL drain_idle_re got %b want 00", {re0, re1}); end
    tick();
    for (int i = 0; i < PX; i++) begin
      drive(0, 1, 0, 0, 1); settle();
      nCmp++; if ({sel_buf1, sel_blank, underrun, re0, re1} !== 5'b00010) begin nFail++; $display("[TB] FAIL drain_re0 px %0d got %b want 00010", i, {sel_buf1, sel_blank, underrun, re0, re1}); end
      nCmp++; if (addr0 !== AW'(i)) begin nFail++; $display("[TB] FAIL drain_addr0 got %0d want %0d", addr0, i); end
      tick();
    end
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({buf0_empty, sel_blank, re0} !== 3'b110) begin nFail++; $display("[TB] FAIL drain_done got %b want 110", {buf0_empty, sel_blank, re0}); end
    tick();
  endtask

  task automatic test_underrun();
    drive(0, 1, 0, 1, 0); settle(); tick();
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({underrun, sel_blank, buf1_empty} !== 3'b110) begin nFail++; $display("[TB] FAIL underrun_pulse got %b want 110", {underrun, sel_blank, buf1_empty}); end
`ifdef DA_UNDERRUN_COUNT_EN
    nCmp++; if (underrun_count !== 16'd1) begin nFail++; $display("[TB] FAIL underrun_count got %0d want 1", underrun_count); end
`endif
    tick(); settle();
    nCmp++; if (underrun !== 1'b0) begin nFail++; $display("[TB] FAIL underrun_one_cycle got %b want 0", underrun); end
    tick();
  endtask

  task automatic test_back_pressure();
    for (int i = 1; i < PX; i++) begin
      drive(0, 1, 1, 0, 0); settle();
      nCmp++; if ({we1, addr1} !== {1'b1, AW'(i)}) begin nFail++; $display("[TB] FAIL bp_fill1 got we1 %b addr1 %0d want 1/%0d", we1, addr1, i); end
      tick();
    end
    for (int i = 0; i < PX; i++) begin
      drive(0, 1, 1, 0, 0); settle();
      nCmp++; if ({we0, addr0} !== {1'b1, AW'(i)}) begin nFail++; $display("[TB] FAIL bp_fill0 got we0 %b addr0 %0d want 1/%0d", we0, addr0, i); end
      tick();
    end
    drive(0, 1, 1, 0, 0); settle();
    nCmp++; if ({fill_ready, we0, we1} !== 3'b000) begin nFail++; $display("[TB] FAIL bp_stall got %b want 000", {fill_ready, we0, we1}); end
    tick();
    drive(0, 1, 1, 1, 0); settle(); tick();
    for (int i = 0; i < PX; i++) begin
      drive(0, 1, 1, 0, 1); settle();
      nCmp++; if ({sel_buf1, sel_blank, fill_ready, re1, addr1} !== {4'b1001, AW'(i)}) begin nFail++; $display("[TB] FAIL bp_drain1 px %0d got %b want %b", i, {sel_buf1, sel_blank, fill_ready, re1, addr1}, {4'b1001, AW'(i)}); end
      tick();
    end
    drive(0, 1, 1, 0, 0); settle();
    nCmp++; if ({fill_ready, we1, addr1} !== {2'b11, AW'(0)}) begin nFail++; $display("[TB] FAIL bp_resume got %b want %b", {fill_ready, we1, addr1}, {2'b11, AW'(0)}); end
    tick();
  endtask

  task automatic test_short_line();
    for (int i = 1; i < PX; i++) begin
      drive(0, 1, 1, 0, 0); settle(); tick();
    end
    drive(0, 1, 0, 1, 0); settle(); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 1); settle();
      nCmp++; if ({re0, addr0} !== {1'b1, AW'(i)}) begin nFail++; $display("[TB] FAIL short_re0 got re0 %b addr0 %0d want 1/%0d", re0, addr0, i); end
      tick();
    end
    drive(0, 1, 0, 1, 0); settle(); tick();
    drive(0, 1, 0, 0, 1); settle();
    nCmp++; if ({sel_buf1, sel_blank, underrun, buf0_empty, re0, re1} !== 6'b100101) begin nFail++; $display("[TB] FAIL short_switch got %b want 100101", {sel_buf1, sel_blank, underrun, buf0_empty, re0, re1}); end
    nCmp++; if (addr1 !== AW'(0)) begin nFail++; $display("[TB] FAIL short_addr1 got %0d want 0", addr1); end
    tick();
  endtask

  task automatic test_cs_low();
    drive(0, 0, 1, 1, 1); settle();
    nCmp++; if ({fill_ready, we0, we1, re0, re1, sel_blank} !== 6'b000001) begin nFail++; $display("[TB] FAIL cs_gate got %b want 000001", {fill_ready, we0, we1, re0, re1, sel_blank}); end
    tick();
    drive(0, 1, 0, 0, 1); settle();
    nCmp++; if ({underrun, sel_blank, re1, addr1} !== {3'b001, AW'(1)}) begin nFail++; $display("[TB] FAIL cs_retain got %b want %b", {underrun, sel_blank, re1, addr1}, {3'b001, AW'(1)}); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    drive(1, 1, 0, 0, 0); settle(); tick();
    for (int i = 0; i < PX + 2; i++) begin
      drive(0, 1, 1, 0, 0); settle(); tick();
    end
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({buf0_empty, buf1_empty, addr1} !== {2'b00, AW'(2)}) begin nFail++; $display("[TB] FAIL midfill_pre got %b want %b", {buf0_empty, buf1_empty, addr1}, {2'b00, AW'(2)}); end
    tick();
    drive(1, 1, 1, 0, 0); settle(); tick();
    drive(0, 1, 0, 0, 0); settle();
    nCmp++; if ({we0, we1, re0, re1, addr0, addr1} !== '0) begin nFail++; $display("[TB] FAIL midfill_comb got %b want 0", {we0, we1, re0, re1, addr0, addr1}); end
    nCmp++; if ({sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun} !== 5'b01110) begin nFail++; $display("[TB] FAIL midfill_regs got %b want 01110", {sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun}); end
`ifdef DA_UNDERRUN_COUNT_EN
    nCmp++; if (underrun_count !== 16'd0) begin nFail++; $display("[TB] FAIL midfill_ucount got %0d want 0", underrun_count); end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [4+2*AW:0] expC;
    logic [4:0]      expR;
    drive(1, 1, 0, 0, 0); settle(); tick();
    for (int cyc = 0; cyc < 800; cyc++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      settle();
      expC = {eReady, eWe[0], eWe[1], eRe[0], eRe[1], AW'(mCnt[0]), AW'(mCnt[1])};
      expR = {mSelBuf1, mSelBlank || !cs_display, mState[0] == S_EMPTY, mState[1] == S_EMPTY, mUnderrun};
      nCmp++; if ({fill_ready, we0, we1, re0, re1, addr0, addr1} !== expC) begin nFail++; $display("[TB] FAIL rnd_comb cyc %0d got %b want %b", cyc, {fill_ready, we0, we1, re0, re1, addr0, addr1}, expC); end
      nCmp++; if ({sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun} !== expR) begin nFail++; $display("[TB] FAIL rnd_regs cyc %0d got %b want %b", cyc, {sel_buf1, sel_blank, buf0_empty, buf1_empty, underrun}, expR); end
`ifdef DA_UNDERRUN_COUNT_EN
      nCmp++; if (underrun_count !== 16'(mUcount)) begin nFail++; $display("[TB] FAIL rnd_ucount cyc %0d got %0d want %0d", cyc, underrun_count, mUcount); end
`endif
      tick();
    end
  endtask

  initial begin
    model_reset();
    drive(1, 1, 0, 0, 0);
    @(posedge clock);
    #1;
    $display("[TB] da_buffer_scheduler bench, PX_PER_LINE=%0d", PX);
    test_reset();
    test_fill();
    test_drain();
    test_underrun();
    test_back_pressure();
    test_short_line();
    test_cs_low();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
